button_conditioner: RTL and testbench
=====================================

# button_conditioner

Conditions the raw mechanical push-button input into clean, glitch-free control signals for the LED toggle logic and any other button consumer. The block provides:
- a 2-flop synchronizer;
- a debounce state machine;
- single-cycle press/release pulses;
- an optional long-press detector.

The block sits between the board pin and the toggle FSM, so downstream logic sees exactly one pulse per physical press.

## Interface
- DEBOUNCE_CYCLES, 16: consecutive synchronized samples required to accept a level change; legal range ≥2.
- LONG_PRESS_CYCLES, 1000: cycles in PRESSED before long_press_pulse; legal range > DEBOUNCE_CYCLES.
- clk  input  1  single system clock, rising-edge.
- reset_n  input  1  asynchronous, active-low reset.
- button_raw  input  1  asynchronous, bouncy pin level; 1 = pressed.
- button_level  output  1  debounced level; 1 = pressed.
- press_pulse  output  1  one-cycle strobe on accepted press.
- release_pulse  output  1  one-cycle strobe on accepted release.
- long_press_pulse  output  1  one-cycle strobe after a sustained hold.

## Operation
- **Synchronizer:** button_raw passes through two flops (s1, s2), both reset to 0. All logic below uses s2 only.
- **FSM states:** IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT. Reset state is IDLE.
- **IDLE:**
  - s2=1 → PRESS_WAIT with deb_cnt=1.
  - Otherwise stay.
- **PRESS_WAIT:**
  - s2=0 (bounce) → IDLE, deb_cnt=0.
  - s2=1 and deb_cnt=DEBOUNCE_CYCLES-1 → PRESSED; press_pulse=1 next cycle; deb_cnt=0; hold_cnt=0.
  - Otherwise deb_cnt+1.
- **PRESSED:**
  - s2=0 → RELEASE_WAIT, deb_cnt=1.
  - Otherwise stay; hold_cnt increments.
- **RELEASE_WAIT:** mirror of PRESS_WAIT with s2 polarity inverted.
  - Success → IDLE and release_pulse.
  - Bounce → PRESSED. hold_cnt resumes and is not cleared.
- **button_level:** 1 in PRESSED and RELEASE_WAIT, 0 otherwise. Registered.
- **Pulse rules:**
  - All pulses are registered and high for exactly one cycle.
  - press_pulse and release_pulse are mutually exclusive by construction.
  - A bounce in either WAIT state never produces a pulse.
- **Counter widths:**
  - deb_cnt is $clog2(DEBOUNCE_CYCLES+1) bits.
  - hold_cnt is $clog2(LONG_PRESS_CYCLES+1) bits and saturates at LONG_PRESS_CYCLES.
  - Neither counter wraps.

## Timing
- **Reset values:** button_level, press_pulse, release_pulse and long_press_pulse are all 0. s1=s2=0, deb_cnt=0, hold_cnt=0.
- **Reset assertion:** takes effect immediately, mid-debounce or mid-hold. Any in-flight pulse is killed.
- **Button held through reset deassertion:** re-debounced from IDLE and produces press_pulse. This is intended.
- **Press latency:**
  - button_raw is stable high before edge E0.
  - s2 is high from E1; samples are taken at E2..E(D+1).
  - press_pulse and button_level rise after E(D+1), where D=DEBOUNCE_CYCLES.
  - This is D+2 edges counting E0.
- **Release latency:** identical, D+2 edges.
- **Long-press latency:** long_press_pulse goes high in the cycle after hold_cnt reaches LONG_PRESS_CYCLES.
- **Long-press repeat:** one pulse per press; no auto-repeat until re-entry via IDLE.
- **Minimum accepted pulse:** an input pulse shorter than D synchronized cycles is rejected entirely.

## Configuration
- **Macro:** BUTTON_LONG_PRESS_EN.
- **Defined:**
  - hold_cnt and the long-press compare are built.
  - long_press_pulse behaves as specified.
- **Undefined:**
  - hold_cnt is not instantiated.
  - long_press_pulse is tied to constant 0.
  - LONG_PRESS_CYCLES is ignored.
  - Port list is unchanged.

## Structure
- **Package button_pkg:**
  - state enum typedef btn_state_t, 2 bits: IDLE=0, PRESS_WAIT=1, PRESSED=2, RELEASE_WAIT=3.
  - localparam defaults for DEBOUNCE_CYCLES and LONG_PRESS_CYCLES.
- **Sub-module sync_2ff:**
  - 1-bit, 2-stage synchronizer with the same clk/reset_n and reset value 0.
  - Reused for other async inputs.
- **Top level:** FSM, counters and output registers live in button_conditioner.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4 and LONG_PRESS_CYCLES=20 with the macro defined, unless stated.
- **Clean press:** raw 0→1 held 10 cycles → press_pulse high exactly once, 6 edges after the change; button_level=1 from the same cycle.
- **Bounce rejected:** raw toggles 1,0,1,0 every cycle, then stable 1 → no pulse during toggling; one press_pulse 6 edges after the final stable 1.
- **Release and long press:** hold 30 cycles then release →
  - press_pulse;
  - long_press_pulse once, 20 cycles after press_pulse;
  - release_pulse once, 6 edges after the release;
  - no second long_press_pulse.
- **Reset mid-debounce:** reset_n low during PRESS_WAIT with raw=1 → all outputs 0 immediately; after deassertion, press_pulse 6 edges later.
- **Short glitch:** raw high 3 cycles → no pulse, button_level stays 0.
- **Macro undefined:** rerun the release/long-press scenario → long_press_pulse stays 0; press and release pulses unchanged.

Source files
------------

// File: rtl/button_pkg.sv
// button_pkg: debounce FSM state encoding and default timing for button_conditioner
package button_pkg;
    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        PRESS_WAIT   = 2'd1,
        PRESSED      = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;
    localparam int DEFAULT_DEBOUNCE_CYCLES   = 16;
    localparam int DEFAULT_LONG_PRESS_CYCLES = 1000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: two-flop synchronizer for a single asynchronous input, reset to 0
module sync_2ff (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);
    logic s1_q, s2_q;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end
    assign q = s2_q;
endmodule

// File: rtl/button_conditioner.sv
// button_conditioner: synchronize, debounce and pulse a push-button; long press built only with BUTTON_LONG_PRESS_EN
module button_conditioner
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES   = DEFAULT_DEBOUNCE_CYCLES,
    parameter int LONG_PRESS_CYCLES = DEFAULT_LONG_PRESS_CYCLES
) (
    input  logic clk,
    input  logic reset_n,
    input  logic button_raw,
    output logic button_level,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_press_pulse
);
    localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [DW-1:0] DEB_LAST = DW'(DEBOUNCE_CYCLES - 1);
    logic s2;
    btn_state_t state_q, state_d;
    logic [DW-1:0] deb_cnt_q, deb_cnt_d;
    logic level_q, level_d, press_q, press_d, release_q, release_d;
    logic hold_clr, hold_inc;
    sync_2ff u_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (button_raw),
        .q       (s2)
    );
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        press_d   = 1'b0;
        release_d = 1'b0;
        hold_clr  = 1'b0;
        hold_inc  = 1'b0;
        case (state_q)
            IDLE: begin
                if (s2) begin
                    state_d   = PRESS_WAIT;
                    deb_cnt_d = DW'(1);
                end
            end
            PRESS_WAIT: begin
                if (!s2) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = PRESSED;
                    deb_cnt_d = '0;
                    press_d   = 1'b1;
                    hold_clr  = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
            PRESSED: begin
                if (!s2) begin
                    state_d   = RELEASE_WAIT;
                    deb_cnt_d = DW'(1);
                end else begin
                    hold_inc  = 1'b1;
                end
            end
            RELEASE_WAIT: begin
                if (s2) begin
                    state_d   = PRESSED;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    state_d   = IDLE;
                    deb_cnt_d = '0;
                    release_d = 1'b1;
                end else begin
                    deb_cnt_d = deb_cnt_q + DW'(1);
                end
            end
        endcase
        level_d = (state_d == PRESSED) || (state_d == RELEASE_WAIT);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            deb_cnt_q <= '0;
            level_q   <= 1'b0;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end
    assign button_level  = level_q;
    assign press_pulse   = press_q;
    assign release_pulse = release_q;
`ifdef BUTTON_LONG_PRESS_EN
    localparam int HW = $clog2(LONG_PRESS_CYCLES + 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_PRESS_CYCLES);
    localparam logic [HW-1:0] HOLD_PRE = HW'(LONG_PRESS_CYCLES - 1);
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;
    logic long_q, long_d;
    always_comb begin
        hold_cnt_d = hold_clr ? '0 :
                     (hold_inc && hold_cnt_q != HOLD_MAX) ? hold_cnt_q + HW'(1) : hold_cnt_q;
        long_d     = hold_inc && (hold_cnt_q == HOLD_PRE);
    end
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hold_cnt_q <= '0;
            long_q     <= 1'b0;
        end else begin
            hold_cnt_q <= hold_cnt_d;
            long_q     <= long_d;
        end
    end
    assign long_press_pulse = long_q;
`else
    logic unused_hold;
    assign unused_hold      = hold_clr ^ hold_inc ^ (LONG_PRESS_CYCLES > 0);
    assign long_press_pulse = 1'b0;
`endif
endmodule

// File: tb/tb_button_conditioner.sv
// tb_button_conditioner: directed stimulus with a pulse scoreboard checked by an independent monitor
module tb_button_conditioner;
    localparam int D = 4;
    localparam int L = 20;
    localparam logic [2:0] EV_P = 3'b100;
    localparam logic [2:0] EV_R = 3'b010;
    localparam logic [2:0] EV_L = 3'b001;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic button_raw = 1'b0;
    logic button_level, press_pulse, release_pulse, long_press_pulse;
    int cyc = 0;
    int checks = 0;
    int failures = 0;
    typedef struct {
        logic [2:0] kind;
        int         at;
    } ev_t;
    ev_t sb[$];
    button_conditioner #(
        .DEBOUNCE_CYCLES   (D),
        .LONG_PRESS_CYCLES (L)
    ) dut (
        .clk              (clk),
        .reset_n          (reset_n),
        .button_raw       (button_raw),
        .button_level     (button_level),
        .press_pulse      (press_pulse),
        .release_pulse    (release_pulse),
        .long_press_pulse (long_press_pulse)
    );
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask
    task automatic expect_ev(input logic [2:0] kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        sb.push_back(e);
    endtask
    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask
    always @(negedge clk) begin
        ev_t e;
        logic [2:0] seen;
        while (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL missed_pulse: got none expected kind %b at cycle %0d", e.kind, e.at);
        end
        seen = {press_pulse, release_pulse, long_press_pulse};
        if (seen != 3'b000) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_pulse: got kind %b at cycle %0d expected none", seen, cyc);
            end else begin
                e = sb.pop_front();
                if (seen !== e.kind || cyc != e.at) begin
                    failures++;
                    $display("FAIL pulse: got kind %b at cycle %0d expected kind %b at cycle %0d",
                             seen, cyc, e.kind, e.at);
                end
            end
        end
    end
    initial begin
        int n, m, k;
        repeat (3) @(negedge clk);
        check("reset_level", button_level, 0);
        check("reset_press", press_pulse, 0);
        check("reset_release", release_pulse, 0);
        check("reset_long", long_press_pulse, 0);
        reset_n = 1'b1;
        repeat (4) @(negedge clk);
        // clean press held 10 cycles
        n = cyc;
        button_raw = 1'b1;
        expect_ev(EV_P, n + 6);
        expect_ev(EV_R, n + 16);
        wait_cyc(n + 5);
        check("clean_level_pre", button_level, 0);
        wait_cyc(n + 6);
        check("clean_level", button_level, 1);
        wait_cyc(n + 10);
        button_raw = 1'b0;
        wait_cyc(n + 15);
        check("clean_level_hold", button_level, 1);
        wait_cyc(n + 16);
        check("clean_level_rel", button_level, 0);
        wait_cyc(n + 26);
        // bounce then stable press
        n = cyc;
        button_raw = 1'b1;
        @(negedge clk) button_raw = 1'b0;
        @(negedge clk) button_raw = 1'b1;
        @(negedge clk) button_raw = 1'b0;
        @(negedge clk) button_raw = 1'b1;
        expect_ev(EV_P, n + 10);
        expect_ev(EV_R, n + 20);
        wait_cyc(n + 9);
        check("bounce_level_pre", button_level, 0);
        wait_cyc(n + 10);
        check("bounce_level", button_level, 1);
        wait_cyc(n + 14);
        button_raw = 1'b0;
        wait_cyc(n + 30);
        // long hold then release
        n = cyc;
        button_raw = 1'b1;
        expect_ev(EV_P, n + 6);
`ifdef BUTTON_LONG_PRESS_EN
        expect_ev(EV_L, n + 26);
`endif
        expect_ev(EV_R, n + 36);
        wait_cyc(n + 30);
        check("long_level", button_level, 1);
        button_raw = 1'b0;
        wait_cyc(n + 36);
        check("long_level_rel", button_level, 0);
        wait_cyc(n + 50);
        // reset kills an in-flight press pulse, then reset mid-debounce
        n = cyc;
        button_raw = 1'b1;
        expect_ev(EV_P, n + 6);
        wait_cyc(n + 6);
        #2 reset_n = 1'b0;
        #1;
        check("rst_kill_press", press_pulse, 0);
        check("rst_kill_level", button_level, 0);
        repeat (2) @(negedge clk);
        m = cyc;
        reset_n = 1'b1;
        expect_ev(EV_P, m + 6);
        wait_cyc(m + 3);
        sb.delete();
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_level", button_level, 0);
        check("rst_mid_press", press_pulse, 0);
        check("rst_mid_release", release_pulse, 0);
        check("rst_mid_long", long_press_pulse, 0);
        repeat (2) @(negedge clk);
        k = cyc;
        reset_n = 1'b1;
        expect_ev(EV_P, k + 6);
        expect_ev(EV_R, k + 14);
        wait_cyc(k + 5);
        check("rst_after_level_pre", button_level, 0);
        wait_cyc(k + 6);
        check("rst_after_level", button_level, 1);
        wait_cyc(k + 8);
        button_raw = 1'b0;
        wait_cyc(k + 20);
        // 3-cycle glitch is rejected
        n = cyc;
        button_raw = 1'b1;
        wait_cyc(n + 3);
        button_raw = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge clk);
            check("glitch_level", button_level, 0);
        end
        repeat (10) @(negedge clk);
        while (sb.size() > 0) begin
            ev_t e;
            e = sb.pop_front();
            checks++;
            failures++;
            $display("FAIL leftover_pulse: got none expected kind %b at cycle %0d", e.kind, e.at);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
